// File: rtl/reg_arb_pkg.sv
// -----------------------------------------------------------------------------
// reg_arb_pkg
// Shared types and the arbitration pick function for the register-bank write
// arbiter.
//   REG_AW       : default register address width (32 registers)
//   REG_WIDTH    : default register data width
//   REG_MAXREQ   : largest supported requester count; rr_pick works on
//                  vectors of this width and ignores bits at or above n
//   reg_addr_t   : register address
//   wr_req_t     : one write request (valid, addr, data)
//   rr_pick()    : one-hot pick of the first valid requester at or after ptr
// -----------------------------------------------------------------------------
package reg_arb_pkg;

  localparam int REG_AW     = 5;
  localparam int REG_WIDTH  = 32;
  localparam int REG_MAXREQ = 8;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic                 valid;
    reg_addr_t            addr;
    logic [REG_WIDTH-1:0] data;
  } wr_req_t;

  // Scan ptr, ptr+1, ... (mod n) and return the first valid requester as a
  // one-hot vector; all zeros when nothing is valid.
  function automatic logic [REG_MAXREQ-1:0] rr_pick(
    input logic [REG_MAXREQ-1:0] valid,
    input logic [2:0]            ptr,
    input int unsigned           n
  );
    logic [REG_MAXREQ-1:0] pick;
    logic                  found;
    logic [2:0]            idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < REG_MAXREQ; k++) begin
      idx = 3'((32'(ptr) + k) % n);
      if ((k < n) && !found && valid[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational one-of-N pick plus the round-robin pointer register.
// Optional feature macro: REG_ARB_FIXED_PRIO_EN -- when defined the pick is
// fixed priority (lowest index wins) and the pointer is held at 0.
// Ports:
//   clk_i      clock
//   rst_n_i    synchronous active-low reset; forces no grant and ptr=0
//   valid_i    per-requester request
//   flush_i    suppresses any grant this cycle, ptr unchanged
//   grant_o    one-hot-or-zero grant
//   gnt_any_o  a grant is issued this cycle
//   gnt_idx_o  index of the granted requester (valid when gnt_any_o)
// -----------------------------------------------------------------------------
module rr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [N-1:0] valid_i,
  input  logic         flush_i,
  output logic [N-1:0] grant_o,
  output logic         gnt_any_o,
  output logic [2:0]   gnt_idx_o
);

  localparam int PW = $clog2(N);
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  logic [PW-1:0]         ptr_q;
  logic [PW-1:0]         ptr_d;
  logic [REG_MAXREQ-1:0] valid_ext_s;
  logic [REG_MAXREQ-1:0] pick_s;
  logic [2:0]            idx_s;
  logic                  any_s;

  // Requests are invisible during reset and flush so no grant can appear.
  always_comb begin
    valid_ext_s = '0;
    if (rst_n_i && !flush_i) begin
      valid_ext_s[N-1:0] = valid_i;
    end else begin
      valid_ext_s = '0;
    end
  end

  // Pick the winner starting from the pointer.
  always_comb begin
`ifdef REG_ARB_FIXED_PRIO_EN
    pick_s = rr_pick(valid_ext_s, 3'd0, N);
`else
    pick_s = rr_pick(valid_ext_s, 3'(ptr_q), N);
`endif
  end

  // Encode the one-hot pick into an index.
  always_comb begin
    idx_s = 3'd0;
    for (int i = 0; i < REG_MAXREQ; i++) begin
      if (pick_s[i]) begin
        idx_s = 3'(i);
      end else begin
        idx_s = idx_s;
      end
    end
    any_s = |pick_s;
  end

  // Next pointer: one past the winner, wrapping at N; held otherwise.
  always_comb begin
    ptr_d = ptr_q;
`ifdef REG_ARB_FIXED_PRIO_EN
    ptr_d = '0;
`else
    if (any_s) begin
      if (32'(idx_s) == (N - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = PW'(idx_s + 3'd1);
      end
    end else begin
      ptr_d = ptr_q;
    end
`endif
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign grant_o   = any_s ? (ONE_HOT0 << idx_s) : '0;
  assign gnt_any_o = any_s;
  assign gnt_idx_o = idx_s;

endmodule

// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
// Shares the register bank's single write port among NREQ writeback
// requesters. One requester is granted per cycle and its write is registered
// into a one-entry commit stage that drives WE3/RA3/WD3 the next cycle.
// Optional feature macro: REG_ARB_FIXED_PRIO_EN (fixed priority instead of
// round-robin).
// Ports:
//   CLK, RST_N        clock, synchronous active-low reset
//   REQ_VALID         per-requester write request
//   REQ_ADDR/REQ_DATA packed per-requester address / data
//   REQ_READY         one-hot-or-zero grant (combinational)
//   FLUSH             drops the commit stage, no grant this cycle
//   WE3/RA3/WD3       bank write port
//   PEND_VALID/ADDR   in-flight write, for forwarding or stalling readers
//   WR_COUNT          committed-write counter, wraps at 2^16
// -----------------------------------------------------------------------------
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int AW    = REG_AW
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NREQ-1:0]       REQ_VALID,
  input  logic [NREQ*AW-1:0]    REQ_ADDR,
  input  logic [NREQ*WIDTH-1:0] REQ_DATA,
  output logic [NREQ-1:0]       REQ_READY,
  input  logic                  FLUSH,
  output logic                  WE3,
  output logic [AW-1:0]         RA3,
  output logic [WIDTH-1:0]      WD3,
  output logic                  PEND_VALID,
  output logic [AW-1:0]         PEND_ADDR,
  output logic [15:0]           WR_COUNT
);

  logic             gnt_any_s;
  logic [2:0]       gnt_idx_s;
  logic [AW-1:0]    sel_addr_s;
  logic [WIDTH-1:0] sel_data_s;

  logic             we_q, we_d;
  logic [AW-1:0]    ra_q, ra_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic [15:0]      cnt_q, cnt_d;

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .clk_i     (CLK),
    .rst_n_i   (RST_N),
    .valid_i   (REQ_VALID),
    .flush_i   (FLUSH),
    .grant_o   (REQ_READY),
    .gnt_any_o (gnt_any_s),
    .gnt_idx_o (gnt_idx_s)
  );

  // Route the winning requester's address and data to the commit stage.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx_s == 3'(i)) begin
        sel_addr_s = REQ_ADDR[i*AW +: AW];
        sel_data_s = REQ_DATA[i*WIDTH +: WIDTH];
      end else begin
        sel_addr_s = sel_addr_s;
      end
    end
  end

  // Commit-stage next state; FLUSH already suppresses the grant upstream.
  always_comb begin
    we_d  = 1'b0;
    ra_d  = ra_q;
    wd_d  = wd_q;
    cnt_d = cnt_q;
    if (gnt_any_s) begin
      we_d  = 1'b1;
      ra_d  = sel_addr_s;
      wd_d  = sel_data_s;
      cnt_d = cnt_q + 16'd1;
    end else begin
      we_d  = 1'b0;
    end
  end

  // Commit stage and counter registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      we_q  <= 1'b0;
      ra_q  <= '0;
      wd_q  <= '0;
      cnt_q <= 16'd0;
    end else begin
      we_q  <= we_d;
      ra_q  <= ra_d;
      wd_q  <= wd_d;
      cnt_q <= cnt_d;
    end
  end

  assign WE3        = we_q;
  assign RA3        = ra_q;
  assign WD3        = wd_q;
  assign PEND_VALID = we_q;
  assign PEND_ADDR  = ra_q;
  assign WR_COUNT   = cnt_q;

endmodule
